// File: rtl/voice_blk_serializer.sv
// Drains the four 16-byte windows of a 64-byte voice frame from the window selector as a valid/ready byte stream.
// Optional VOICE_SER_MARK_EN adds out_sof/out_eof frame markers aligned with out_data.
module voice_blk_serializer #(
   parameter int NBYTES  = 16,
   parameter int NWIN    = 4,
   parameter int SEL_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [8*NBYTES-1:0] in_data,
   output logic [1:0]          win_sel,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                frame_done
`ifdef VOICE_SER_MARK_EN
   ,
   output logic                out_sof,
   output logic                out_eof
`endif
);

   localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int WW = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int SW = (SEL_LAT > 0) ? $clog2(SEL_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, LOAD, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [BW-1:0]       byte_q, byte_d;
   logic [WW-1:0]       wcnt_q, wcnt_d;
   logic [1:0]          sel_q, sel_d;
   logic [8*NBYTES-1:0] shift_q, shift_d;
   logic [7:0]          data_q, data_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef VOICE_SER_MARK_EN
   logic                sof_q, sof_d;
   logic                eof_q, eof_d;
`endif

   logic last_byte, last_win, accept;
   assign last_byte = (byte_q == BW'(NBYTES - 1));
   assign last_win  = (wcnt_q == WW'(NWIN - 1));
   assign accept    = valid_q && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         byte_q   <= '0;
         wcnt_q   <= '0;
         sel_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef VOICE_SER_MARK_EN
         sof_q    <= 1'b0;
         eof_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         byte_q   <= byte_d;
         wcnt_q   <= wcnt_d;
         sel_q    <= sel_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef VOICE_SER_MARK_EN
         sof_q    <= sof_d;
         eof_q    <= eof_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      byte_d   = byte_q;
      wcnt_d   = wcnt_q;
      sel_d    = sel_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef VOICE_SER_MARK_EN
      sof_d    = sof_q;
      eof_d    = eof_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d    = 2'd0;
               wcnt_d   = '0;
               settle_d = SW'(SEL_LAT);
               busy_d   = 1'b1;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            // Wait out the selector's registered latency before sampling in_data.
            if (settle_q == '0) state_d = LOAD;
            else                settle_d = settle_q - SW'(1);
         end
         LOAD: begin
            shift_d = in_data;
            data_d  = in_data[8*NBYTES-1 -: 8];
            valid_d = 1'b1;
            byte_d  = '0;
            state_d = SHIFT;
`ifdef VOICE_SER_MARK_EN
            sof_d   = (wcnt_q == '0);
            eof_d   = last_win && (NBYTES == 1);
`endif
         end
         SHIFT: begin
            if (accept) begin
               if (!last_byte) begin
                  shift_d = shift_q << 8;
                  data_d  = shift_d[8*NBYTES-1 -: 8];
                  byte_d  = byte_q + BW'(1);
`ifdef VOICE_SER_MARK_EN
                  sof_d   = 1'b0;
                  eof_d   = last_win && ((byte_q + BW'(1)) == BW'(NBYTES - 1));
`endif
               end else if (!last_win) begin
                  valid_d  = 1'b0;
                  wcnt_d   = wcnt_q + WW'(1);
                  sel_d    = sel_q + 2'd1;
                  settle_d = SW'(SEL_LAT);
                  state_d  = SETTLE;
`ifdef VOICE_SER_MARK_EN
                  sof_d    = 1'b0;
                  eof_d    = 1'b0;
`endif
               end else begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  sel_d   = 2'd0;
                  wcnt_d  = '0;
                  state_d = IDLE;
`ifdef VOICE_SER_MARK_EN
                  sof_d   = 1'b0;
                  eof_d   = 1'b0;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign win_sel    = sel_q;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
`ifdef VOICE_SER_MARK_EN
   assign out_sof    = sof_q;
   assign out_eof    = eof_q;
`endif

endmodule

// File: tb/tb_voice_blk_serializer.sv
// Bench for voice_blk_serializer: a 64-byte memory stands in for the window selector and is the expected stream.
// Define VOICE_SER_MARK_EN for both bench and RTL to exercise the frame markers.
module tb_voice_blk_serializer;
   localparam int NBYTES  = 16;
   localparam int NWIN    = 4;
   localparam int SEL_LAT = 1;
   localparam int FB      = NBYTES * NWIN;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [8*NBYTES-1:0] in_data;
   logic [1:0]          win_sel;
   logic [7:0]          out_data;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic                busy;
   logic                frame_done;
`ifdef VOICE_SER_MARK_EN
   logic                out_sof, out_eof;
`endif

   voice_blk_serializer #(.NBYTES(NBYTES), .NWIN(NWIN), .SEL_LAT(SEL_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .win_sel(win_sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done)
`ifdef VOICE_SER_MARK_EN
      , .out_sof(out_sof), .out_eof(out_eof)
`endif
   );

   always #5 clk = ~clk;

   // Selector model: one registered stage between win_sel and its window.
   logic [7:0] mem [FB];
   logic [1:0] sel_q = 2'd0;
   always @(posedge clk) sel_q <= win_sel;
   always_comb begin
      in_data = '0;
      for (int i = 0; i < NBYTES; i++)
         in_data[8*NBYTES-1-8*i -: 8] = mem[int'(sel_q)*NBYTES + i];
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, halfway between active edges.
   logic [7:0] acc_q[$];
   int  done_cnt = 0, gap = 0;
   bit  meas = 0, prev_v = 0, prev_r = 0, prev_busy = 0;
   logic [7:0] prev_d = 0;
`ifdef VOICE_SER_MARK_EN
   bit prev_sof = 0, prev_eof = 0;
`endif
   always @(negedge clk) begin
      if (rst) begin
         meas = 0; prev_v = 0; prev_r = 0; prev_busy = 0;
      end else begin
         if (meas) begin
            if (!out_valid) gap++;
            else begin
               chk("bubble_cycles", gap, SEL_LAT + 2);
               chk("win_sel_step", win_sel, acc_q.size() / NBYTES);
               meas = 0;
            end
         end
         if (prev_v && !prev_r) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_data_held", out_data, prev_d);
`ifdef VOICE_SER_MARK_EN
            chk("stall_sof_held", out_sof, prev_sof);
            chk("stall_eof_held", out_eof, prev_eof);
`endif
         end
         if (out_valid && out_ready) begin
            int idx;
            idx = acc_q.size();
            acc_q.push_back(out_data);
`ifdef VOICE_SER_MARK_EN
            chk("sof_mark", out_sof, idx == 0);
            chk("eof_mark", out_eof, idx == FB - 1);
`endif
            if (idx % NBYTES == NBYTES - 1 && idx < FB - 1) begin
               meas = 1; gap = 0;
            end
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_busy_low", busy, 0);
            chk("done_busy_was_high", prev_busy, 1);
            chk("done_byte_count", acc_q.size(), FB);
            chk("done_win_sel", win_sel, 0);
         end
         prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_busy = busy;
`ifdef VOICE_SER_MARK_EN
         prev_sof = out_sof; prev_eof = out_eof;
`endif
      end
   end

   task automatic fill_mem(input int rnd);
      for (int i = 0; i < FB; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   // rdy_mode: 0 always ready, 1 toggling during window 1, 2 random.
   task automatic run_frame(input int rdy_mode, input int xstart);
      int cyc, done0;
      bit xdone, tog;
      acc_q.delete();
      done0 = done_cnt; xdone = 0; tog = 0; cyc = 0;
      @(posedge clk); #1 start = 1; out_ready = 1;
      @(posedge clk); #1 start = 0;
      while (done_cnt == done0 && cyc < 3000) begin
         tog = ~tog;
         case (rdy_mode)
            1: out_ready = (acc_q.size() >= NBYTES && acc_q.size() < 2*NBYTES) ? tog : 1'b1;
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
         if (!xdone && xstart >= 0 && acc_q.size() >= xstart) begin
            start = 1; xdone = 1;
         end else start = 0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 0;
      out_ready = 1;
      chk("frame_completed", done_cnt - done0, 1);
      repeat (30) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int rnd_mem;
      int rdy_mode;
      int xstart;
      int exp_bytes;
      int exp_done;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int d0, c;
      fill_mem(0);
      tbl[0] = '{0, 0, -1, FB, 1};
      tbl[1] = '{0, 1, -1, FB, 1};
      tbl[2] = '{1, 2, -1, FB, 1};
      tbl[3] = '{1, 0,  5, FB, 1};
      tbl[4] = '{1, 2, 40, FB, 1};
      tbl[5] = '{1, 1,  5, FB, 1};

      #12;
      chk("rst_win_sel", win_sel, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
`ifdef VOICE_SER_MARK_EN
      chk("rst_sof", out_sof, 0);
      chk("rst_eof", out_eof, 0);
`endif
      @(posedge clk); #3 rst = 0;

      foreach (tbl[k]) begin
         fill_mem(tbl[k].rnd_mem);
         d0 = done_cnt;
         run_frame(tbl[k].rdy_mode, tbl[k].xstart);
         chk("vec_byte_count", acc_q.size(), tbl[k].exp_bytes);
         chk("vec_done_count", done_cnt - d0, tbl[k].exp_done);
         chk("vec_idle_busy", busy, 0);
         for (int i = 0; i < FB && i < acc_q.size(); i++)
            chk($sformatf("vec%0d_byte%0d", k, i), acc_q[i], mem[i]);
      end

      // Reset in window 2, just after byte 0x23 is accepted.
      fill_mem(0);
      acc_q.delete();
      d0 = done_cnt; c = 0;
      @(posedge clk); #1 start = 1; out_ready = 1;
      @(posedge clk); #1 start = 0;
      while (acc_q.size() < 36 && c < 500) begin
         @(negedge clk); c++;
      end
      chk("midrst_reached_0x23", acc_q.size(), 36);
      #2 rst = 1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_win_sel", win_sel, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_done", frame_done, 0);
      repeat (3) @(posedge clk);
      #3 rst = 0;
      repeat (5) @(posedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      run_frame(0, -1);
      chk("midrst_restart_count", acc_q.size(), FB);
      chk("midrst_restart_first", acc_q.size() > 0 ? acc_q[0] : 8'hFF, 8'h00);
      for (int i = 0; i < FB && i < acc_q.size(); i++)
         chk($sformatf("restart_byte%0d", i), acc_q[i], mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
      $fatal(1, "timeout");
   end
endmodule
